aud_recorder: RTL

I2S receive-side capture block: deserialises one channel of the audio CODEC ADC bit stream (AUD_ADCDAT) into 16-bit samples, MSB first. Produces SRAM write strobes with a sequential address. Runs in the i_bclk domain alongside the DAC player. Under top-level control it starts, pauses, resumes and stops recording, and flags completion when the address space is full.

---
 rtl/aud_recorder.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/aud_recorder.sv
// aud_recorder: I2S receive-side capture block.
//
// Deserialises one channel of the CODEC ADC bit stream into DATA_W-bit
// samples (MSB first) and emits one SRAM write strobe per captured sample
// with a sequential address. Recording can be started, paused, resumed and
// stopped. o_done rises once MAX_ADDR has been written.
//
// Ports:
//   i_bclk     CODEC bit clock, all logic on its rising edge
//   i_rst      synchronous active-high reset
//   i_adclrck  ADC LR clock (0 = left, 1 = right)
//   i_adcdat   ADC serial data
//   i_start    start from IDLE (address back to 0) or resume from PAUSED
//   i_pause    pause request (takes effect after the word in flight)
//   i_stop     abort and return to IDLE
//   o_address  SRAM write address, valid with o_valid
//   o_data     captured sample, valid with o_valid, held between strobes
//   o_valid    single-cycle write strobe
//   o_busy     high while armed or shifting
//   o_done     high after the MAX_ADDR write until the next start
module aud_recorder #(
  parameter int                DATA_W   = 16,
  parameter int                ADDR_W   = 20,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 20'hFFFFF,
  parameter logic              CHANNEL  = 1'b0
) (
  input  logic              i_bclk,
  input  logic              i_rst,
  input  logic              i_adclrck,
  input  logic              i_adcdat,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_busy,
  output logic              o_done
);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] COMMIT   = CNT_W'(DATA_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARMED  = 2'd1,
    SHIFT  = 2'd2,
    PAUSED = 2'd3
  } state_t;

  state_t            state;
  logic              prev_lrck;
  logic [DATA_W-2:0] shift_reg;
  logic [CNT_W-1:0]  bit_cnt;
  logic              pause_pend;
  logic [ADDR_W-1:0] addr_cnt;
  logic              chan_edge;

  // Start of the captured channel's half-frame; its MSB arrives one bclk later.
  assign chan_edge = (prev_lrck != CHANNEL) && (i_adclrck == CHANNEL);

  // Capture FSM. In SHIFT, bit_cnt 0..DATA_W-1 are sampling cycles and
  // bit_cnt == DATA_W is the commit cycle that drops the strobe, advances
  // the address and chooses the next state.
  always_ff @(posedge i_bclk) begin
    if (i_rst) begin
      state      <= IDLE;
      prev_lrck  <= 1'b0;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      pause_pend <= 1'b0;
      addr_cnt   <= '0;
      o_address  <= '0;
      o_data     <= '0;
      o_valid    <= 1'b0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      prev_lrck <= i_adclrck;
      o_valid   <= 1'b0;
      case (state)
        IDLE: begin
          if (i_start && !i_stop) begin
            state      <= ARMED;
            o_busy     <= 1'b1;
            addr_cnt   <= '0;
            o_done     <= 1'b0;
            pause_pend <= 1'b0;
          end
        end
        ARMED: begin
          if (i_stop) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end else if (i_pause) begin
            state  <= PAUSED;
            o_busy <= 1'b0;
          end else if (chan_edge) begin
            state   <= SHIFT;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (i_stop) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            pause_pend <= 1'b0;
          end else if (bit_cnt == COMMIT) begin
            pause_pend <= 1'b0;
            if (addr_cnt == MAX_ADDR) begin
              // Address space exhausted: no wrap, recording ends here.
              state  <= IDLE;
              o_busy <= 1'b0;
              o_done <= 1'b1;
            end else begin
              addr_cnt <= addr_cnt + 1'b1;
              if (pause_pend || i_pause) begin
                state  <= PAUSED;
                o_busy <= 1'b0;
              end else begin
                state <= ARMED;
              end
            end
          end else if ((bit_cnt != LAST_BIT) && (i_adclrck != CHANNEL)) begin
            // Channel ended early: drop the partial word, keep the address.
            // A pause requested during the dropped word still takes effect.
            pause_pend <= 1'b0;
            if (pause_pend || i_pause) begin
              state  <= PAUSED;
              o_busy <= 1'b0;
            end else begin
              state <= ARMED;
            end
          end else begin
            shift_reg <= {shift_reg[DATA_W-3:0], i_adcdat};
            bit_cnt   <= bit_cnt + 1'b1;
            if (i_pause) begin
              pause_pend <= 1'b1;
            end
            if (bit_cnt == LAST_BIT) begin
              o_data    <= {shift_reg, i_adcdat};
              o_address <= addr_cnt;
              o_valid   <= 1'b1;
            end
          end
        end
        PAUSED: begin
          if (i_stop) begin
            state <= IDLE;
          end else if (i_start) begin
            state  <= ARMED;
            o_busy <= 1'b1;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
